// File: rtl/des_key_scheduler_if.sv
// Key-schedule bus: load request and key in, 48-bit subkey stream out.
// The scheduler sits on the master side because it sources the subkey stream.
interface des_key_scheduler_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        abort;
  logic        k_ready;
  logic        k_valid;
  logic [47:0] subkey;
  logic [4:0]  round;
  logic        busy;
  logic        done;
  logic        key_err;

  modport master (
    input  start, decrypt, key, abort, k_ready,
    output k_valid, subkey, round, busy, done, key_err
  );

  modport slave (
    output start, decrypt, key, abort, k_ready,
    input  k_valid, subkey, round, busy, done, key_err
  );
endinterface

// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: one rotate/PC-2 stage walked by a round counter.
// Optional DES_KS_PARITY_CHECK_EN rejects keys whose bytes lack odd parity.
module des_key_scheduler (
  input  logic                       clk,
  input  logic                       rst_n,
  des_key_scheduler_if.master        ks
);

  typedef enum logic {IDLE, RUN} state_t;

  // Tables use DES bit numbering: bit 1 is the MSB.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_reg, state_next;
  logic [27:0] c_reg, c_next, d_reg, d_next;
  logic [4:0]  step_reg, step_next;
  logic        mode_reg, mode_next;
  logic        done_reg, done_next;
  logic        key_err_reg, key_err_next;

  logic [55:0] cd_load;
  logic [55:0] cd_sel;
  logic [47:0] pc2_out;
  logic [4:0]  round_idx;
  logic        single_shift;
  logic [27:0] c_rotl, d_rotl, c_rotr, d_rotr;
  logic        k_valid_int;
  logic        fire;
  logic        parity_ok;

  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign cd_load[55-gi] = ks.key[64-PC1_TAB[gi]];
  end

`ifdef DES_KS_PARITY_CHECK_EN
  logic [7:0] byte_odd;
  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    assign byte_odd[gi] = ^ks.key[8*gi +: 8];
  end
  assign parity_ok = &byte_odd;
`else
  assign parity_ok = 1'b1;
`endif

  // Encrypt at step r shifts by s[r]; decrypt at step r undoes s[17-r].
  // Both equal s[round_idx], so one shift lookup serves both orders.
  assign round_idx    = mode_reg ? (5'd17 - step_reg) : step_reg;
  assign single_shift = (round_idx == 5'd1) || (round_idx == 5'd2) ||
                        (round_idx == 5'd9) || (round_idx == 5'd16);

  assign c_rotl = single_shift ? {c_reg[26:0], c_reg[27]}    : {c_reg[25:0], c_reg[27:26]};
  assign d_rotl = single_shift ? {d_reg[26:0], d_reg[27]}    : {d_reg[25:0], d_reg[27:26]};
  assign c_rotr = single_shift ? {c_reg[0], c_reg[27:1]}     : {c_reg[1:0], c_reg[27:2]};
  assign d_rotr = single_shift ? {d_reg[0], d_reg[27:1]}     : {d_reg[1:0], d_reg[27:2]};

  // Decrypt starts from C16/D16 == C0/D0, so its subkey uses the unrotated halves.
  assign cd_sel = mode_reg ? {c_reg, d_reg} : {c_rotl, d_rotl};

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign pc2_out[47-gi] = cd_sel[56-PC2_TAB[gi]];
  end

  assign k_valid_int = (state_reg == RUN);
  assign fire        = k_valid_int & ks.k_ready & ~ks.abort;

  assign ks.k_valid = k_valid_int;
  assign ks.subkey  = k_valid_int ? pc2_out : 48'd0;
  assign ks.round   = k_valid_int ? round_idx : 5'd0;
  assign ks.busy    = k_valid_int;
  assign ks.done    = done_reg;
  assign ks.key_err = key_err_reg;

  always_comb begin
    state_next   = state_reg;
    c_next       = c_reg;
    d_next       = d_reg;
    step_next    = step_reg;
    mode_next    = mode_reg;
    done_next    = 1'b0;
    key_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ks.start) begin
          if (parity_ok) begin
            c_next     = cd_load[55:28];
            d_next     = cd_load[27:0];
            mode_next  = ks.decrypt;
            step_next  = 5'd1;
            state_next = RUN;
          end else begin
            key_err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (ks.abort) begin
          step_next  = 5'd0;
          state_next = IDLE;
        end else if (fire) begin
          c_next = mode_reg ? c_rotr : c_rotl;
          d_next = mode_reg ? d_rotr : d_rotl;
          if (step_reg == 5'd16) begin
            step_next  = 5'd0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            step_next = step_reg + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      c_reg       <= '0;
      d_reg       <= '0;
      step_reg    <= '0;
      mode_reg    <= 1'b0;
      done_reg    <= 1'b0;
      key_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      c_reg       <= c_next;
      d_reg       <= d_next;
      step_reg    <= step_next;
      mode_reg    <= mode_next;
      done_reg    <= done_next;
      key_err_reg <= key_err_next;
    end
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler: directed scenarios plus random keys,
// compared against a direct (non-iterative) DES key-schedule model.
module tb_des_key_scheduler;

  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY1 = 64'h133557799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int S_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  des_key_scheduler_if ks();

  des_key_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Subkey r straight from the definition: PC-1, cumulative left rotation, PC-2.
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
    logic        b  [56];
    logic        rb [56];
    logic [47:0] sk;
    int          sh = 0;
    for (int i = 0; i < 56; i++) b[i] = k[64-PC1_T[i]];
    for (int i = 0; i < r; i++) sh += S_T[i];
    for (int i = 0; i < 28; i++) begin
      rb[i]      = b[(i + sh) % 28];
      rb[28 + i] = b[28 + (i + sh) % 28];
    end
    for (int j = 0; j < 48; j++) sk[47-j] = rb[PC2_T[j]-1];
    return sk;
  endfunction

  function automatic bit model_key_ok(input logic [63:0] k);
`ifdef DES_KS_PARITY_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      logic [7:0] by;
      by = k[8*i +: 8];
      if (!(^by)) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  // One key load; abort_at/pulse_at/stall_round name a DES round (0 = unused).
  task automatic run_key(input logic [63:0] k, input logic dec, input int ready_pct,
                         input int stall_round, input int abort_at, input int pulse_at,
                         input int exp_cyc, input bit kat);
    logic [47:0] exp_sk [1:16];
    int hs, cyc, stalled, er;
    bit rdy;
    for (int r = 1; r <= 16; r++) exp_sk[r] = model_subkey(k, r);
    ks.key = k; ks.decrypt = dec; ks.start = 1'b1;
    tick();
    ks.start = 1'b0; ks.key = {$urandom, $urandom}; ks.decrypt = ~dec;
    if (!model_key_ok(k)) begin
      chk("key_err_set", ks.key_err, 1);
      chk("rej_valid", ks.k_valid, 0);
      tick();
      chk("key_err_clr", ks.key_err, 0);
      chk("rej_busy", ks.busy, 0);
      $display("key %h dec=%0d rejected (parity)", k, dec);
      return;
    end
    hs = 0; cyc = 0; stalled = 0;
    while (hs < 16 && cyc < 400) begin
      er = dec ? 16 - hs : hs + 1;
      chk("k_valid", ks.k_valid, 1);
      chk("busy", ks.busy, 1);
      chk("done_run", ks.done, 0);
      chk("key_err_run", ks.key_err, 0);
      chk("round", ks.round, er);
      chk("subkey", ks.subkey, exp_sk[er]);
      if (kat && er == 1)  chk("kat_k1", ks.subkey, 48'h1B02EFFC7072);
      if (kat && er == 16) chk("kat_k16", ks.subkey, 48'hCB3D8B0E17F5);
      rdy = ($urandom_range(99) < ready_pct);
      if (er == stall_round && stalled < 3) begin rdy = 1'b0; stalled++; end
      ks.k_ready = rdy;
      if (pulse_at == er) begin ks.start = 1'b1; ks.key = {$urandom, $urandom}; end
      if (abort_at == er && rdy) begin
        ks.abort = 1'b1;
        tick();
        ks.abort = 1'b0; ks.k_ready = 1'b0; ks.start = 1'b0;
        chk("abort_valid", ks.k_valid, 0);
        chk("abort_busy", ks.busy, 0);
        chk("abort_done", ks.done, 0);
        chk("abort_round", ks.round, 0);
        tick();
        chk("abort_done2", ks.done, 0);
        $display("key %h dec=%0d aborted at round %0d after %0d handshakes", k, dec, er, hs);
        return;
      end
      tick();
      ks.start = 1'b0;
      if (rdy) hs++;
      cyc++;
    end
    chk("handshakes", hs, 16);
    if (exp_cyc != 0) chk("cycles", cyc, exp_cyc);
    chk("done_pulse", ks.done, 1);
    chk("end_valid", ks.k_valid, 0);
    chk("end_busy", ks.busy, 0);
    chk("end_subkey", ks.subkey, 0);
    chk("end_round", ks.round, 0);
    ks.k_ready = 1'b0;
    tick();
    chk("done_clr", ks.done, 0);
    $display("key %h dec=%0d: %0d handshakes in %0d cycles", k, dec, hs, cyc);
  endtask

  initial begin
    rst_n = 1'b0;
    ks.start = 1'b0; ks.decrypt = 1'b0; ks.key = '0; ks.abort = 1'b0; ks.k_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", ks.k_valid, 0);
    chk("rst_subkey", ks.subkey, 0);
    chk("rst_round", ks.round, 0);
    chk("rst_busy", ks.busy, 0);
    chk("rst_done", ks.done, 0);
    chk("rst_key_err", ks.key_err, 0);
    rst_n = 1'b1;
    tick();

    ks.abort = 1'b1;
    tick();
    ks.abort = 1'b0;
    chk("idle_abort_busy", ks.busy, 0);
    chk("idle_abort_done", ks.done, 0);
    $display("abort in IDLE: busy=%0d done=%0d", ks.busy, ks.done);

    run_key(KEY0, 1'b0, 100, 0, 0, 0, 16, 1'b1);
    run_key(KEY0, 1'b1, 100, 0, 0, 0, 16, 1'b1);
    run_key(KEY0, 1'b0, 100, 5, 0, 0, 19, 1'b1);
    run_key(KEY0, 1'b0, 100, 0, 8, 0, 0, 1'b1);
    run_key(KEY1, 1'b0, 100, 0, 0, 0, 16, 1'b1);
    run_key(KEY0, 1'b1, 100, 0, 0, 4, 16, 1'b1);

    // Asynchronous reset mid-run: outputs must clear before the next edge.
    ks.key = KEY0; ks.decrypt = 1'b0; ks.start = 1'b1;
    tick();
    ks.start = 1'b0; ks.k_ready = 1'b1;
    repeat (5) tick();
    chk("pre_rst_busy", ks.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ks.k_valid, 0);
    chk("arst_subkey", ks.subkey, 0);
    chk("arst_round", ks.round, 0);
    chk("arst_busy", ks.busy, 0);
    chk("arst_done", ks.done, 0);
    tick();
    rst_n = 1'b1; ks.k_ready = 1'b0;
    tick();
    chk("post_rst_busy", ks.busy, 0);
    chk("post_rst_done", ks.done, 0);
    $display("async reset mid-run: valid=%0d busy=%0d", ks.k_valid, ks.busy);

    for (int n = 0; n < 8; n++) begin
      logic [63:0] rk;
      rk = {$urandom, $urandom};
      run_key(rk, 1'($urandom_range(1)), 60, (n % 2 == 0) ? int'($urandom_range(1, 16)) : 0,
              0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
